pipelined_adder: RTL and testbench

Parametrised, pipelined two-operand binary adder; successor to the team's combinational 64-bit adder. Operands are split into STAGES equal chunks, and each pipeline stage resolves one chunk's sum and carry, so wide adds close timing at high clock rates. A valid/ready handshake with full-pipeline stall lets it sit between streaming datapath blocks. Adds carry-out and signed-overflow flags.

---
 rtl/pipelined_adder.sv | 136 +++++++++++++
 tb/tb_pipelined_adder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Chunked, carry-skewed pipelined adder with a valid/ready handshake and a full-pipeline stall.
// Define ADDER_SUB_EN to add a per-operation subtract control (sub port).
module pipelined_adder #(
   parameter int WIDTH  = 64,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
`ifdef ADDER_SUB_EN
   input  logic             sub,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] sum,
   output logic             Cout,
   output logic             ovf,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int CW = WIDTH / STAGES;

   logic             w_advance;
   logic [WIDTH-1:0] w_b_in;
   logic             w_cin_in;
   logic             r_ovf;

`ifdef ADDER_SUB_EN
   // Subtraction is folded in at entry: A + ~B + 1, so later stages only ever add.
   assign w_b_in   = sub ? ~B : B;
   assign w_cin_in = sub | Cin;
`else
   assign w_b_in   = B;
   assign w_cin_in = Cin;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         localparam int UW = WIDTH - (gi + 1) * CW;
         localparam int SW = (gi + 1) * CW;

         logic [CW-1:0] w_a_chunk;
         logic [CW-1:0] w_b_chunk;
         logic          w_cin;
         logic          w_vin;
         logic [CW:0]   w_chunk_sum;
         logic [SW-1:0] w_sum_next;
         logic          r_valid;
         logic          r_carry;
         logic [SW-1:0] r_sum;

         if (gi == 0) begin : g_head
            assign w_a_chunk  = A[CW-1:0];
            assign w_b_chunk  = w_b_in[CW-1:0];
            assign w_cin      = w_cin_in;
            assign w_vin      = in_valid;
            assign w_sum_next = w_chunk_sum[CW-1:0];
         end else begin : g_body
            assign w_a_chunk  = g_stage[gi-1].g_fwd.r_a[CW-1:0];
            assign w_b_chunk  = g_stage[gi-1].g_fwd.r_b[CW-1:0];
            assign w_cin      = g_stage[gi-1].r_carry;
            assign w_vin      = g_stage[gi-1].r_valid;
            assign w_sum_next = {w_chunk_sum[CW-1:0], g_stage[gi-1].r_sum};
         end

         assign w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CW{1'b0}}, w_cin};

         // Data only loads for real operations, so bubbles leave the last result in place.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_valid <= 1'b0;
               r_carry <= 1'b0;
               r_sum   <= '0;
            end else if (w_advance) begin
               r_valid <= w_vin;
               if (w_vin) begin
                  r_carry <= w_chunk_sum[CW];
                  r_sum   <= w_sum_next;
               end
            end
         end

         if (gi < STAGES - 1) begin : g_fwd
            logic [UW-1:0] w_a_up;
            logic [UW-1:0] w_b_up;
            logic [UW-1:0] r_a;
            logic [UW-1:0] r_b;

            if (gi == 0) begin : g_src_in
               assign w_a_up = A[WIDTH-1:CW];
               assign w_b_up = w_b_in[WIDTH-1:CW];
            end else begin : g_src_reg
               assign w_a_up = g_stage[gi-1].g_fwd.r_a[UW+CW-1:CW];
               assign w_b_up = g_stage[gi-1].g_fwd.r_b[UW+CW-1:CW];
            end

            always_ff @(posedge clk or posedge reset) begin
               if (reset) begin
                  r_a <= '0;
                  r_b <= '0;
               end else if (w_advance && w_vin) begin
                  r_a <= w_a_up;
                  r_b <= w_b_up;
               end
            end
         end

         if (gi == STAGES - 1) begin : g_tail
            logic w_ovf;
            // Operand MSBs live in this stage's chunk, so the sign test stays local.
            assign w_ovf = (w_a_chunk[CW-1] == w_b_chunk[CW-1]) &&
                           (w_chunk_sum[CW-1] != w_a_chunk[CW-1]);

            always_ff @(posedge clk or posedge reset) begin
               if (reset) begin
                  r_ovf <= 1'b0;
               end else if (w_advance && w_vin) begin
                  r_ovf <= w_ovf;
               end
            end
         end
      end
   endgenerate

   assign out_valid = g_stage[STAGES-1].r_valid;
   assign sum       = g_stage[STAGES-1].r_sum;
   assign Cout      = g_stage[STAGES-1].r_carry;
   assign ovf       = r_ovf;
   assign w_advance = ~out_valid | out_ready;
   assign in_ready  = w_advance;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: vector table, stall/backpressure stream, async reset mid-stream.
module tb_pipelined_adder;
   localparam int WIDTH  = 64;
   localparam int STAGES = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] sum;
   logic             Cout;
   logic             ovf;
   logic             out_valid;
   logic             out_ready;
`ifdef ADDER_SUB_EN
   logic             sub;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [63:0] a;
      logic [63:0] b;
      logic        cin;
      logic        sb;
      logic [63:0] exp_sum;
      logic        exp_cout;
      logic        exp_ovf;
   } vec_t;

   vec_t vecs [9];

   pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk       (clk),
      .reset     (reset),
      .A         (A),
      .B         (B),
      .Cin       (Cin),
`ifdef ADDER_SUB_EN
      .sub       (sub),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sum       (sum),
      .Cout      (Cout),
      .ovf       (ovf),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Issue one operation, measure its latency, check the result and the one-cycle valid pulse.
   task automatic run_vec(input vec_t v, input string tag);
      int lat;
      lat = 0;
      @(negedge clk);
      A = v.a; B = v.b; Cin = v.cin; in_valid = 1'b1; out_ready = 1'b1;
`ifdef ADDER_SUB_EN
      sub = v.sb;
`endif
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         if (c == 1) begin
            in_valid = 1'b0; A = ~v.a; B = ~v.b; Cin = ~v.cin;
         end
         if (out_valid === 1'b1) begin
            lat = c;
            break;
         end
      end
      check({tag, "_latency"}, 64'(lat), 64'(STAGES));
      check({tag, "_sum"}, sum, v.exp_sum);
      check({tag, "_cout"}, 64'(Cout), 64'(v.exp_cout));
      check({tag, "_ovf"}, 64'(ovf), 64'(v.exp_ovf));
      @(posedge clk); #1;
      check({tag, "_pulse"}, 64'(out_valid), 64'd0);
      $display("vec %s: A=%h B=%h Cin=%0b sum=%h Cout=%0b ovf=%0b lat=%0d", tag, v.a, v.b, v.cin, sum, Cout, ovf, lat);
   endtask

   initial begin
      logic [63:0] exp_q [$];
      logic [63:0] exp_front;
      int sent, got, stray;

      vecs[0] = '{64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0};
      vecs[1] = '{64'h3000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, 1'b0, 64'h7000_0000_0000_0000, 1'b0, 1'b0};
      vecs[2] = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
      vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
      vecs[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
      vecs[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1};
      vecs[6] = '{64'h0000_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0001_0000_0000_0000, 1'b0, 1'b0};
      vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
      vecs[8] = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};

      reset = 1'b1; A = '0; B = '0; Cin = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
`ifdef ADDER_SUB_EN
      sub = 1'b0;
`endif
      #12;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_sum", sum, 64'd0);
      check("rst_cout", 64'(Cout), 64'd0);
      check("rst_ovf", 64'(ovf), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      $display("reset: out_valid=%0b sum=%h in_ready=%0b", out_valid, sum, in_ready);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 9; i++) begin
         run_vec(vecs[i], $sformatf("v%0d", i));
      end

      // Back-to-back stream with three cycles of downstream backpressure.
      sent = 0; got = 0;
      @(negedge clk);
      for (int t = 0; t < 40 && got < 6; t++) begin
         out_ready = !(t >= 5 && t <= 7);
         in_valid  = (sent < 6);
         A = 64'(sent + 1); B = 64'hFFFF_FFFF; Cin = 1'b1;
         #1;
         exp_front = (exp_q.size() > 0) ? exp_q[0] : 64'hDEAD_DEAD_DEAD_DEAD;
         if (t >= 5 && t <= 7) begin
            check($sformatf("stall_in_ready_t%0d", t), 64'(in_ready), 64'd0);
            check($sformatf("stall_hold_t%0d", t), sum, exp_front);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL stream_extra: got %h want no output", sum);
            end else begin
               check($sformatf("stream_sum%0d", got), sum, exp_q.pop_front());
            end
            $display("stream t=%0d out sum=%h", t, sum);
            got++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(64'h1_0000_0000 + 64'(sent + 1));
            sent++;
         end
         @(negedge clk);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      check("stream_sent", 64'(sent), 64'd6);
      check("stream_got", 64'(got), 64'd6);

      // Asynchronous reset with three operations in flight.
      for (int i = 0; i < 3; i++) begin
         A = 64'(i + 10); B = 64'd5; Cin = 1'b0; in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      check("prerst_valid", 64'(out_valid), 64'd1);
      check("prerst_sum", sum, 64'd15);
      reset = 1'b1;
      #1;
      check("arst_out_valid", 64'(out_valid), 64'd0);
      check("arst_sum", sum, 64'd0);
      check("arst_cout", 64'(Cout), 64'd0);
      $display("async reset: out_valid=%0b sum=%h", out_valid, sum);
      @(negedge clk);
      reset = 1'b0;
      stray = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (out_valid) stray++;
      end
      check("arst_stray", 64'(stray), 64'd0);
      run_vec(vecs[2], "post_rst");

`ifdef ADDER_SUB_EN
      run_vec('{64'd10, 64'd3, 1'b1, 1'b1, 64'd7, 1'b1, 1'b0}, "sub0");
      run_vec('{64'd3, 64'd10, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 1'b0}, "sub1");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
